// File: rtl/ccm_ctr_burst_pipe_aes_if.sv
// ccm_ctr_burst_pipe_aes_if: burst request, keystream handshake and status bundle
interface ccm_ctr_burst_pipe_aes_if #(
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20
);
  localparam int WIDTH_KEY = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT;
  logic [WIDTH_KEY-1:0]   key_aes;
  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce;
  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag;
  logic [WIDTH_COUNT-1:0] ctr_start;
  logic [WIDTH_COUNT-1:0] num_blocks;
  logic                   start;
  logic                   encrypt_rdy;
  logic [WIDTH_KEY-1:0]   encrypt_data;
  logic                   encrypt_en;
  logic                   busy;
  logic                   done;
  logic                   ctr_wrap;
  modport master (
    output key_aes, ccm_ctr_nonce, ccm_ctr_flag, ctr_start, num_blocks, start, encrypt_rdy,
    input  encrypt_data, encrypt_en, busy, done, ctr_wrap
  );
  modport slave (
    input  key_aes, ccm_ctr_nonce, ccm_ctr_flag, ctr_start, num_blocks, start, encrypt_rdy,
    output encrypt_data, encrypt_en, busy, done, ctr_wrap
  );
endinterface

// File: rtl/ccm_ctr_burst_pipe_aes.sv
// ccm_ctr_burst_pipe_aes: CCM counter-block burst issuer with stand-in cipher pipe and credit-guarded output FIFO
module ccm_ctr_burst_pipe_aes #(
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20,
  parameter int AES_LAT     = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                  clk,
  input logic                  kill,
  ccm_ctr_burst_pipe_aes_if.slave bus
);
  localparam int WIDTH_KEY = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + AES_LAT + 1);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, next;
  logic accept, issue, fin, wr, pop, room, en;
  logic [WIDTH_KEY-1:0] key_q;
  logic [WIDTH_NONCE-1:0] nonce_q;
  logic [WIDTH_FLAG-1:0] flag_q;
  logic [WIDTH_COUNT-1:0] cnt, rem;
  logic busy, done, wrap;
  logic [WIDTH_KEY-1:0] pipe [1:AES_LAT];
  logic [AES_LAT:1] pv;
  logic [WIDTH_KEY-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fcnt;
  logic [OW-1:0] occ;
  // Every in-flight block already owns a FIFO slot, so the pipe never has to stall.
  always_comb begin
    occ = OW'(fcnt);
    for (int i = 1; i <= AES_LAT; i++) occ = occ + OW'(pv[i]);
  end
  assign room = occ < OW'(FIFO_DEPTH);
  assign en   = fcnt != '0;
  assign wr   = pv[AES_LAT];
  assign pop  = en & bus.encrypt_rdy;
  assign bus.encrypt_en   = en;
  assign bus.encrypt_data = en ? mem[rptr] : '0;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.ctr_wrap = wrap;
  always_ff @(posedge clk or posedge kill) begin
    if (kill) state <= IDLE;
    else      state <= next;
  end
  always_comb begin
    next   = state;
    accept = 1'b0;
    issue  = 1'b0;
    fin    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start;
        next   = bus.start ? (bus.num_blocks == '0 ? DRAIN : ISSUE) : IDLE;
      end
      ISSUE: begin
        issue = room;
        next  = room && rem == WIDTH_COUNT'(1) ? DRAIN : ISSUE;
      end
      DRAIN: begin
        fin  = pv == '0 && fcnt == '0;
        next = fin ? IDLE : DRAIN;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      cnt  <= '0;
      rem  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      pv   <= '0;
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      done <= fin;
      if (accept) begin
        cnt  <= bus.ctr_start;
        rem  <= bus.num_blocks;
        wrap <= 1'b0;
        busy <= 1'b1;
      end
      if (issue) begin
        cnt <= cnt + WIDTH_COUNT'(1);
        rem <= rem - WIDTH_COUNT'(1);
        if (&cnt && rem > WIDTH_COUNT'(1)) wrap <= 1'b1;
      end
      if (fin) busy <= 1'b0;
      pv[1] <= issue;
      for (int i = 2; i <= AES_LAT; i++) pv[i] <= pv[i-1];
      if (wr) wptr <= wptr == LAST ? '0 : wptr + AW'(1);
      if (pop) rptr <= rptr == LAST ? '0 : rptr + AW'(1);
      fcnt <= fcnt + CW'(wr) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      key_q   <= bus.key_aes;
      nonce_q <= bus.ccm_ctr_nonce;
      flag_q  <= bus.ccm_ctr_flag;
    end
    pipe[1] <= {flag_q, nonce_q, cnt} ^ key_q;
    for (int i = 2; i <= AES_LAT; i++) pipe[i] <= pipe[i-1];
    if (wr) mem[wptr] <= pipe[AES_LAT];
  end
endmodule

// File: tb/tb_ccm_ctr_burst_pipe_aes.sv
// tb_ccm_ctr_burst_pipe_aes: directed bursts with a queue scoreboard drained by a negedge monitor
module tb_ccm_ctr_burst_pipe_aes;
  localparam int WN = 100, WF = 8, WC = 20, WK = 128;
  localparam logic [WK-1:0] K1 = {8{16'hff00}};
  localparam logic [WK-1:0] K3 = 128'h0123456789abcdef_fedcba9876543210;
  logic clk = 1'b0;
  logic kill = 1'b1;
  logic [WK-1:0] exp_q [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ccm_ctr_burst_pipe_aes_if #(.WIDTH_NONCE(WN), .WIDTH_FLAG(WF), .WIDTH_COUNT(WC)) bus ();
  ccm_ctr_burst_pipe_aes #(.WIDTH_NONCE(WN), .WIDTH_FLAG(WF), .WIDTH_COUNT(WC), .AES_LAT(10), .FIFO_DEPTH(4))
    dut (.clk(clk), .kill(kill), .bus(bus));
  function automatic logic [WK-1:0] blk(input logic [WK-1:0] k, input logic [WF-1:0] f,
                                        input logic [WN-1:0] n, input logic [WC-1:0] c);
    return {f, n, c} ^ k;
  endfunction
  task automatic chk(input string name, input logic [WK-1:0] got, input logic [WK-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask
  task automatic pulse_start(input logic [WK-1:0] k, input logic [WN-1:0] n, input logic [WF-1:0] f,
                             input logic [WC-1:0] cs, input logic [WC-1:0] nb);
    @(posedge clk); #1;
    bus.key_aes = k;
    bus.ccm_ctr_nonce = n;
    bus.ccm_ctr_flag = f;
    bus.ctr_start = cs;
    bus.num_blocks = nb;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int max, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk(name, WK'(seen), WK'(1));
    chk({name, "_busy"}, WK'(bus.busy), WK'(0));
    chk({name, "_drained"}, WK'(exp_q.size()), WK'(0));
  endtask
  always @(negedge clk) begin
    if (!kill && bus.encrypt_en && bus.encrypt_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected got %h required no beat", bus.encrypt_data);
      end else chk("beat", bus.encrypt_data, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end
  initial begin
    int run;
    bus.key_aes = '0;
    bus.ccm_ctr_nonce = '0;
    bus.ccm_ctr_flag = '0;
    bus.ctr_start = '0;
    bus.num_blocks = '0;
    bus.start = 1'b0;
    bus.encrypt_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", WK'(bus.encrypt_en), WK'(0));
    chk("rst_data", bus.encrypt_data, '0);
    chk("rst_busy", WK'(bus.busy), WK'(0));
    chk("rst_done", WK'(bus.done), WK'(0));
    chk("rst_wrap", WK'(bus.ctr_wrap), WK'(0));
    kill = 1'b0;
    exp_q.push_back(128'hff00ff00ff00ff00ff00ff00ff00ff01);
    exp_q.push_back(128'hff00ff00ff00ff00ff00ff00ff00ff02);
    exp_q.push_back(128'hff00ff00ff00ff00ff00ff00ff00ff03);
    pulse_start(K1, '0, '0, 20'h1, 20'd3);
    chk("t1_busy", WK'(bus.busy), WK'(1));
    repeat (10) @(posedge clk);
    #1 chk("t1_lat_early", WK'(bus.encrypt_en), WK'(0));
    @(posedge clk);
    #1 chk("t1_lat_first", WK'(bus.encrypt_en), WK'(1));
    wait_done(40, "t1_done");
    exp_q.push_back({8'ha5, 100'h1, 20'hffffe});
    exp_q.push_back({8'ha5, 100'h1, 20'hfffff});
    exp_q.push_back({8'ha5, 100'h1, 20'h00000});
    pulse_start('0, 100'h1, 8'ha5, 20'hffffe, 20'd3);
    wait_done(60, "t2_done");
    chk("t2_wrap", WK'(bus.ctr_wrap), WK'(1));
    repeat (3) @(negedge clk);
    chk("t2_wrap_hold", WK'(bus.ctr_wrap), WK'(1));
    for (int i = 0; i < 16; i++) exp_q.push_back(blk(K3, 8'h3c, 100'habc, WC'(20'h100 + i)));
    @(posedge clk);
    #1 bus.encrypt_rdy = 1'b0;
    pulse_start(K3, 100'habc, 8'h3c, 20'h100, 20'd16);
    chk("t3_wrap_clr", WK'(bus.ctr_wrap), WK'(0));
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i % 10 == 0 && i >= 20) begin
        chk("t3_hold_en", WK'(bus.encrypt_en), WK'(1));
        chk("t3_hold_data", bus.encrypt_data, exp_q[0]);
      end
    end
    @(posedge clk);
    #1 bus.encrypt_rdy = 1'b1;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.encrypt_en) break;
      run++;
    end
    chk("t3_pending", WK'(run), WK'(4));
    wait_done(300, "t3_done");
    pulse_start(K1, '0, '0, 20'h9, 20'd0);
    chk("t4_busy", WK'(bus.busy), WK'(1));
    chk("t4_done_early", WK'(bus.done), WK'(0));
    @(posedge clk);
    #1;
    chk("t4_done", WK'(bus.done), WK'(1));
    chk("t4_busy_clr", WK'(bus.busy), WK'(0));
    chk("t4_en", WK'(bus.encrypt_en), WK'(0));
    @(posedge clk);
    #1;
    chk("t4_done_clr", WK'(bus.done), WK'(0));
    chk("t4_en_quiet", WK'(bus.encrypt_en), WK'(0));
    for (int i = 0; i < 4; i++) exp_q.push_back(blk(K3, 8'h11, 100'h5a5, WC'(7 + i)));
    pulse_start(K3, 100'h5a5, 8'h11, 20'h7, 20'd4);
    repeat (3) @(posedge clk);
    #1;
    bus.ccm_ctr_nonce = 100'hdead;
    bus.ctr_start = 20'h77;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(80, "t5_done");
    repeat (15) @(negedge clk);
    chk("t5_quiet", WK'(bus.encrypt_en), WK'(0));
    for (int i = 0; i < 8; i++) exp_q.push_back(blk(K1, 8'h22, 100'h3, WC'(20'h10 + i)));
    pulse_start(K1, 100'h3, 8'h22, 20'h10, 20'd8);
    run = 0;
    while (exp_q.size() > 6 && run < 100) begin
      @(negedge clk);
      #1 run++;
    end
    chk("t6_reach", WK'(exp_q.size()), WK'(6));
    @(posedge clk);
    #1 kill = 1'b1;
    #1;
    chk("t6_kill_en", WK'(bus.encrypt_en), WK'(0));
    chk("t6_kill_data", bus.encrypt_data, '0);
    chk("t6_kill_busy", WK'(bus.busy), WK'(0));
    chk("t6_kill_done", WK'(bus.done), WK'(0));
    exp_q.delete();
    @(posedge clk);
    #1 kill = 1'b0;
    exp_q.push_back(blk(K1, 8'h22, 100'h3, 20'h5));
    exp_q.push_back(blk(K1, 8'h22, 100'h3, 20'h6));
    pulse_start(K1, 100'h3, 8'h22, 20'h5, 20'd2);
    wait_done(60, "t6_done");
    repeat (15) @(negedge clk);
    chk("t6_quiet", WK'(bus.encrypt_en), WK'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
